// File: rtl/conv_sched_pkg.sv
// Shared sensor package: scheduler state encoding and default parameter values.
package conv_sched_pkg;

  localparam int DEF_WAKE_CYC   = 4;
  localparam int DEF_DISCARD    = 2;
  localparam int DEF_NSAMP_LOG2 = 8;
  localparam int DEF_TIMEOUT    = 1023;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAKE,
    ST_SETTLE,
    ST_ACCUM,
    ST_DONE
  } state_e;

endpackage

// File: rtl/conv_sched_accum.sv
// Sample counter, ones accumulator and inter-pulse watchdog for one conversion.
// Everything is held at zero whenever the scheduler is outside SETTLE/ACCUM.
module conv_accum #(
  parameter int NSAMP_LOG2 = 8,
  parameter int TIMEOUT    = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,          // SETTLE or ACCUM: watchdog active
  input  logic                  accum_en,     // ACCUM: samples are counted
  input  logic                  core_valid,
  input  logic                  core_bit,
  output logic                  last_sample,  // this pulse is the final sample
  output logic                  timeout,      // next cycle is TIMEOUT cycles after the last pulse
  output logic [NSAMP_LOG2:0]   acc_next      // accumulator including the current bit
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [NSAMP_LOG2-1:0] samp_q, samp_d;
  logic [NSAMP_LOG2:0]   acc_q, acc_d;
  logic [WD_W-1:0]       wd_q, wd_d;

  // Next-state logic for counter, accumulator and watchdog.
  // wd_q counts cycles elapsed since the last core_valid (the pulse cycle is 0).
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    samp_d      = samp_q;
    acc_d       = acc_q;
    wd_d        = wd_q;
    acc_next    = acc_q + (NSAMP_LOG2 + 1)'(core_bit);
    last_sample = run && accum_en && core_valid && (samp_q == '1);
    timeout     = run && !core_valid && (wd_q == WD_W'(TIMEOUT - 1));
    if (!run) begin
      samp_d = '0;
      acc_d  = '0;
      wd_d   = '0;
    end else begin
      wd_d = core_valid ? WD_W'(1) : wd_q + WD_W'(1);
      if (accum_en && core_valid) begin
        samp_d = samp_q + NSAMP_LOG2'(1);
        acc_d  = acc_next;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (reset) begin
      samp_q <= '0;
      acc_q  <= '0;
      wd_q   <= '0;
    end else begin
      samp_q <= samp_d;
      acc_q  <= acc_d;
      wd_q   <= wd_d;
    end
  end

endmodule

// File: rtl/conv_sched.sv
// Conversion scheduler: arbitrates host/timer requests, sequences the sensor
// core through wake, settle and accumulation, and publishes the ones count.
module conv_sched
  import conv_sched_pkg::*;
#(
  parameter int WAKE_CYC   = DEF_WAKE_CYC,
  parameter int DISCARD    = DEF_DISCARD,
  parameter int NSAMP_LOG2 = DEF_NSAMP_LOG2,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_host,
  input  logic                req_tmr,
  input  logic                core_valid,
  input  logic                core_bit,
  output logic                core_rst,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                grant_src,
  output logic [NSAMP_LOG2:0] result
);

  // Shared phase counter: wake cycles in WAKE, discarded pulses in SETTLE.
  localparam int PH_MAX = (WAKE_CYC > DISCARD) ? WAKE_CYC : DISCARD;
  localparam int CNT_W  = $clog2(PH_MAX + 1);

  state_e               state_q, state_d;
  logic                 pend_host_q, pend_host_d;
  logic                 pend_tmr_q, pend_tmr_d;
  logic [CNT_W-1:0]     ph_cnt_q, ph_cnt_d;
  logic                 grant_src_q, grant_src_d;
  logic [NSAMP_LOG2:0]  result_q, result_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 core_rst_q, core_rst_d;

  logic                 last_sample;
  logic                 timeout;
  logic [NSAMP_LOG2:0]  acc_next;

  conv_accum #(
    .NSAMP_LOG2 (NSAMP_LOG2),
    .TIMEOUT    (TIMEOUT)
  ) u_accum (
    .clk         (clk),
    .reset       (reset),
    .run         ((state_q == ST_SETTLE) || (state_q == ST_ACCUM)),
    .accum_en    (state_q == ST_ACCUM),
    .core_valid  (core_valid),
    .core_bit    (core_bit),
    .last_sample (last_sample),
    .timeout     (timeout),
    .acc_next    (acc_next)
  );

  // Sequencing, arbitration and output decode; outputs follow the next state
  // so they are registered yet aligned with the state they describe.
  always_comb begin
    state_d     = state_q;
    pend_host_d = pend_host_q | req_host;
    pend_tmr_d  = pend_tmr_q | req_tmr;
    ph_cnt_d    = ph_cnt_q;
    grant_src_d = grant_src_q;
    result_d    = result_q;
    err_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A request arriving in the very cycle its source is granted is served by that grant.
        if (pend_host_q) begin
          grant_src_d = 1'b1;
          pend_host_d = 1'b0;
          ph_cnt_d    = '0;
          state_d     = ST_WAKE;
        end else if (pend_tmr_q) begin
          grant_src_d = 1'b0;
          pend_tmr_d  = 1'b0;
          ph_cnt_d    = '0;
          state_d     = ST_WAKE;
        end
      end
      ST_WAKE: begin
        if (ph_cnt_q == CNT_W'(WAKE_CYC - 1)) begin
          ph_cnt_d = '0;
          state_d  = (DISCARD == 0) ? ST_ACCUM : ST_SETTLE;
        end else begin
          ph_cnt_d = ph_cnt_q + CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (timeout) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (core_valid) begin
          if (ph_cnt_q == CNT_W'(DISCARD - 1)) begin
            ph_cnt_d = '0;
            state_d  = ST_ACCUM;
          end else begin
            ph_cnt_d = ph_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_ACCUM: begin
        if (timeout) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (last_sample) begin
          result_d = acc_next;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        ph_cnt_d = '0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    done_d     = (state_d == ST_DONE);
    busy_d     = (state_d != ST_IDLE);
    core_rst_d = (state_d == ST_IDLE) || (state_d == ST_WAKE) || (state_d == ST_DONE);
  end

  // Registered state and outputs; reset parks the core and drops all requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pend_host_q <= 1'b0;
      pend_tmr_q  <= 1'b0;
      ph_cnt_q    <= '0;
      grant_src_q <= 1'b0;
      result_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      core_rst_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      pend_host_q <= pend_host_d;
      pend_tmr_q  <= pend_tmr_d;
      ph_cnt_q    <= ph_cnt_d;
      grant_src_q <= grant_src_d;
      result_q    <= result_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      core_rst_q  <= core_rst_d;
    end
  end

  assign core_rst  = core_rst_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign grant_src = grant_src_q;
  assign result    = result_q;

endmodule

// File: doc/conv_sched.md
CONV_SCHED -- requirements
Module: conv_sched

Interface
REQ-001 SHALL have parameter WAKE_CYC, default 4: cycles core_rst is held high at conversion start.
REQ-002 SHALL have parameter DISCARD, default 2: initial core_valid pulses ignored per conversion.
REQ-003 SHALL have parameter NSAMP_LOG2, default 8: number of accumulated samples is 2^NSAMP_LOG2.
REQ-004 SHALL have parameter TIMEOUT, default 1023: maximum cycles allowed between core_valid pulses.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port req_host, input, 1: one-cycle host conversion request pulse.
REQ-008 SHALL have port req_tmr, input, 1: one-cycle periodic-timer conversion request pulse.
REQ-009 SHALL have port core_valid, input, 1: one-cycle pulse from the sensor core marking a new decision.
REQ-010 SHALL have port core_bit, input, 1: comparator decision, sampled only when core_valid=1.
REQ-011 SHALL have port core_rst, output, 1: holds the sensor core in reset/precharge when high.
REQ-012 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-013 SHALL have port done, output, 1: one-cycle pulse when result is updated.
REQ-014 SHALL have port err, output, 1: one-cycle pulse, coincident with done, on watchdog timeout.
REQ-015 SHALL have port grant_src, output, 1: source of the current/last conversion (1=host, 0=timer).
REQ-016 SHALL have port result, output, NSAMP_LOG2+1: count of core_bit=1 over the accumulation window.

Function
REQ-017 SHALL implement states IDLE, WAKE, SETTLE, ACCUM, DONE.
REQ-018 SHALL keep one sticky pending flag per source, set by its request pulse in any state, cleared only on grant.
REQ-019 SHALL, in IDLE with any pending flag set, grant host over timer, clear the granted flag, load grant_src, go to WAKE next cycle.
REQ-020 SHALL coalesce repeated requests from one source into a single pending flag.
REQ-021 SHALL, on simultaneous req_host and req_tmr in IDLE, grant host and leave timer pending; the timer is granted in the cycle after the host conversion's DONE.
REQ-022 SHALL drive core_rst=1 for exactly WAKE_CYC cycles in WAKE, then go to SETTLE with core_rst=0.
REQ-023 SHALL, in SETTLE, count core_valid pulses and enter ACCUM after the DISCARD-th pulse; with DISCARD=0, go directly WAKE->ACCUM.
REQ-024 SHALL, in ACCUM, increment sample counter on every core_valid and add core_bit to the accumulator; enter DONE on the 2^NSAMP_LOG2-th pulse, including that pulse's bit.
REQ-025 SHALL size the accumulator NSAMP_LOG2+1 bits so all-ones input yields exactly 2^NSAMP_LOG2 with no wrap.
REQ-026 SHALL run a watchdog in SETTLE and ACCUM, cleared by every core_valid; on reaching TIMEOUT cycles without a pulse, go to DONE with err asserted.
REQ-027 SHALL, in DONE (one cycle), pulse done, copy accumulator to result (result unchanged if err), clear counters, return to IDLE.
REQ-028 SHALL hold core_rst=1 in IDLE and DONE so the core stays parked between conversions.
REQ-029 SHALL ignore core_valid in IDLE, WAKE and DONE.
REQ-030 SHALL keep result stable between done pulses.

Reset
REQ-031 SHALL, while reset=1, force state IDLE, pending flags 0, counters 0, result 0, grant_src 0, busy 0, done 0, err 0, core_rst 1.
REQ-032 SHALL, on reset asserted mid-conversion, abandon it without a done pulse; requests coincident with reset are dropped.

Structure
REQ-033 SHALL place the state enum and default parameter constants in the shared sensor package.
REQ-034 SHALL use one sub-module, conv_accum, containing sample counter, accumulator and watchdog.

Verification
REQ-035 Host request, DISCARD=2, NSAMP_LOG2=8, core_bit=1 on 64 of 256 samples -> done after 258th valid pulse, result=64, err=0, grant_src=1.
REQ-036 req_host and req_tmr same cycle -> host conversion first; timer granted cycle after DONE; exactly two done pulses.
REQ-037 Three req_tmr pulses during a busy conversion -> exactly one further conversion.
REQ-038 core_valid stops mid-ACCUM -> done and err pulse TIMEOUT cycles after last valid; result keeps previous value.
REQ-039 reset asserted in ACCUM -> next cycle IDLE, core_rst=1, result=0, no done pulse.
REQ-040 All 256 core_bit=1 -> result=256 (no wrap).
